// File: rtl/spike_port_initiator.sv
// Core-side initiator for one interconnect port: buffers spike writes in a FIFO,
// issues them under a grant handshake, and runs single outstanding reads with a timeout.
module spike_port_initiator #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wr_valid,
   input  logic [ADDR_WIDTH-1:0]         wr_n_addr,
   input  logic [DATA_WIDTH-1:0]         wr_data,
   output logic                          wr_ready,
   input  logic                          rd_req,
   input  logic [ADDR_WIDTH-1:0]         rd_n_addr,
   output logic                          rd_busy,
   output logic                          rd_done,
   output logic [DATA_WIDTH-1:0]         rd_data,
   output logic                          rd_err,
   output logic [ADDR_WIDTH-1:0]         ic_n_addr_out,
   output logic [DATA_WIDTH-1:0]         ic_data_out,
   output logic                          ic_write_en,
   output logic                          ic_read_en,
   input  logic                          ic_grant,
   input  logic                          ic_resp_valid,
   input  logic [DATA_WIDTH-1:0]         ic_data_in,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, WRITE, RD_REQ, RD_WAIT} state_t;

   state_t                  state_reg, state_next;
   logic [ADDR_WIDTH-1:0]   addr_mem [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]   data_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]        count_reg, count_next;
   logic [ADDR_WIDTH-1:0]   rd_addr_reg, rd_addr_next;
   logic [TMR_W-1:0]        tmr_reg, tmr_next;
   logic [DATA_WIDTH-1:0]   rd_data_reg, rd_data_next;
   logic                    rd_done_reg, rd_done_next;
   logic                    rd_err_reg, rd_err_next;
   logic                    push, pop;

   // wr_ready comes from the registered count, so a pop cannot make room for a push in the same cycle
   assign wr_ready   = (count_reg != CNT_W'(FIFO_DEPTH));
   assign push       = wr_valid && wr_ready;
   assign fifo_count = count_reg;
   assign rd_data    = rd_data_reg;
   assign rd_done    = rd_done_reg;
   assign rd_err     = rd_err_reg;

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_reg] <= wr_n_addr;
         data_mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         rd_addr_reg <= '0;
         tmr_reg     <= '0;
         rd_data_reg <= '0;
         rd_done_reg <= 1'b0;
         rd_err_reg  <= 1'b0;
      end else begin
         state_reg   <= state_next;
         count_reg   <= count_next;
         rd_addr_reg <= rd_addr_next;
         tmr_reg     <= tmr_next;
         rd_data_reg <= rd_data_next;
         rd_done_reg <= rd_done_next;
         rd_err_reg  <= rd_err_next;
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
   end

   // ic_* outputs depend only on registered state and FIFO storage, never on ic_grant
   always_comb begin
      state_next    = state_reg;
      pop           = 1'b0;
      rd_addr_next  = rd_addr_reg;
      tmr_next      = tmr_reg;
      rd_data_next  = rd_data_reg;
      rd_done_next  = 1'b0;
      rd_err_next   = 1'b0;
      ic_write_en   = 1'b0;
      ic_read_en    = 1'b0;
      ic_n_addr_out = '0;
      ic_data_out   = '0;
      rd_busy       = 1'b0;
      case (state_reg)
         IDLE: begin
            // an entry arriving this cycle still beats a pending read
            if (count_reg != '0 || push) begin
               state_next = WRITE;
            end else if (rd_req) begin
               state_next   = RD_REQ;
               rd_addr_next = rd_n_addr;
            end
         end
         WRITE: begin
            ic_write_en   = 1'b1;
            ic_n_addr_out = addr_mem[rd_ptr_reg];
            ic_data_out   = data_mem[rd_ptr_reg];
            if (ic_grant) begin
               pop = 1'b1;
               if (count_reg > CNT_W'(1) || push) state_next = WRITE;
               else                                state_next = IDLE;
            end
         end
         RD_REQ: begin
            ic_read_en    = 1'b1;
            ic_n_addr_out = rd_addr_reg;
            rd_busy       = 1'b1;
            if (ic_grant) begin
               state_next = RD_WAIT;
               tmr_next   = '0;
            end
         end
         RD_WAIT: begin
            rd_busy = 1'b1;
            if (ic_resp_valid) begin
               rd_data_next = ic_data_in;
               rd_done_next = 1'b1;
               state_next   = IDLE;
            end else if (tmr_reg == TMR_W'(TIMEOUT - 1)) begin
               rd_done_next = 1'b1;
               rd_err_next  = 1'b1;
               state_next   = IDLE;
            end else begin
               tmr_next = tmr_reg + TMR_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_spike_port_initiator.sv
// Bench for spike_port_initiator: queue model of the write FIFO checked every cycle,
// plus directed scenarios with literal expectations for ordering, reads, timeout and reset.
module tb_spike_port_initiator;

   localparam int AW = 2;
   localparam int DW = 32;
   localparam int DEPTH = 4;
   localparam int TMO = 15;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_valid;
   logic [AW-1:0] wr_n_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ready;
   logic          rd_req;
   logic [AW-1:0] rd_n_addr;
   logic          rd_busy;
   logic          rd_done;
   logic [DW-1:0] rd_data;
   logic          rd_err;
   logic [AW-1:0] ic_n_addr_out;
   logic [DW-1:0] ic_data_out;
   logic          ic_write_en;
   logic          ic_read_en;
   logic          ic_grant;
   logic          ic_resp_valid;
   logic [DW-1:0] ic_data_in;
   logic [2:0]    fifo_count;

   spike_port_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .wr_valid(wr_valid), .wr_n_addr(wr_n_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_req(rd_req), .rd_n_addr(rd_n_addr), .rd_busy(rd_busy), .rd_done(rd_done),
      .rd_data(rd_data), .rd_err(rd_err),
      .ic_n_addr_out(ic_n_addr_out), .ic_data_out(ic_data_out),
      .ic_write_en(ic_write_en), .ic_read_en(ic_read_en), .ic_grant(ic_grant),
      .ic_resp_valid(ic_resp_valid), .ic_data_in(ic_data_in), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   int          rd_issue_cyc = 0;
   logic [AW-1:0] exp_rd_addr = '0;
   wr_t         q[$];
   wr_t         wlog[$];
   int          wlog_cyc[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
      chk({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
      chk({tag, "_write_en"}, 32'(ic_write_en), 32'd0);
      chk({tag, "_read_en"}, 32'(ic_read_en), 32'd0);
      chk({tag, "_rd_busy"}, 32'(rd_busy), 32'd0);
      chk({tag, "_rd_done"}, 32'(rd_done), 32'd0);
      chk({tag, "_rd_err"}, 32'(rd_err), 32'd0);
      chk({tag, "_rd_data"}, rd_data, 32'd0);
      chk({tag, "_ic_addr"}, 32'(ic_n_addr_out), 32'd0);
      chk({tag, "_ic_data"}, ic_data_out, 32'd0);
   endtask

   // Model: FIFO as a queue; inputs are stable from #1 after posedge, so the
   // values seen here are the ones the next posedge will act on.
   always @(negedge clk) begin : model
      bit  push_ok;
      wr_t e;
      cyc++;
      if (reset) begin
         q.delete();
         chk_reset_outputs("rst");
      end else begin
         chk("fifo_count", 32'(fifo_count), 32'(q.size()));
         chk("wr_ready", 32'(wr_ready), 32'(q.size() < DEPTH));
         chk("en_exclusive", 32'(ic_write_en & ic_read_en), 32'd0);
         if (ic_write_en) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL write_head: got write_en=1 required no write (model FIFO empty)");
            end else begin
               chk("write_addr", 32'(ic_n_addr_out), 32'(q[0].a));
               chk("write_data", ic_data_out, q[0].d);
            end
         end
         if (ic_read_en) begin
            chk("read_addr", 32'(ic_n_addr_out), 32'(exp_rd_addr));
            chk("read_data_out", ic_data_out, 32'd0);
            rd_issue_cyc = ic_grant ? cyc : rd_issue_cyc;
         end
         if (rd_done) done_cnt++;
         push_ok = wr_valid && (q.size() < DEPTH);
         if (ic_write_en && ic_grant && q.size() > 0) begin
            wlog.push_back(q[0]);
            wlog_cyc.push_back(cyc);
            void'(q.pop_front());
         end
         if (push_ok) begin
            e.a = wr_n_addr;
            e.d = wr_data;
            q.push_back(e);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      int lat;
      int d0;
      reset = 1'b1;
      wr_valid = 1'b0; wr_n_addr = '0; wr_data = '0;
      rd_req = 1'b0; rd_n_addr = '0;
      ic_grant = 1'b0; ic_resp_valid = 1'b0; ic_data_in = '0;
      repeat (3) step();
      chk_reset_outputs("init");
      reset = 1'b0;
      step();

      // 1: two writes under constant grant go out back-to-back
      base = wlog.size();
      ic_grant = 1'b1;
      wr_valid = 1'b1; wr_n_addr = 2'b01; wr_data = 32'hA5A5A5A5;
      step();
      wr_n_addr = 2'b10; wr_data = 32'hAAAAAAAA;
      step();
      wr_valid = 1'b0;
      step(); step();
      chk("t1_count", 32'(wlog.size() - base), 32'd2);
      if (wlog.size() - base == 2) begin
         chk("t1_w0_addr", 32'(wlog[base].a), 32'd1);
         chk("t1_w0_data", wlog[base].d, 32'hA5A5A5A5);
         chk("t1_w1_addr", 32'(wlog[base+1].a), 32'd2);
         chk("t1_w1_data", wlog[base+1].d, 32'hAAAAAAAA);
         chk("t1_consecutive", 32'(wlog_cyc[base+1] - wlog_cyc[base]), 32'd1);
      end
      chk("t1_fifo_empty", 32'(fifo_count), 32'd0);
      chk("t1_idle", 32'(ic_write_en), 32'd0);

      // 2: fill without grant, fifth push dropped, then drain 4
      ic_grant = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wr_valid = 1'b1; wr_n_addr = 2'(i); wr_data = 32'h1000 + 32'(i);
         step();
         if (i == 3) begin
            chk("t2_full_ready", 32'(wr_ready), 32'd0);
            chk("t2_full_count", 32'(fifo_count), 32'd4);
         end
      end
      wr_valid = 1'b0;
      chk("t2_drop_count", 32'(fifo_count), 32'd4);
      base = wlog.size();
      ic_grant = 1'b1;
      repeat (6) step();
      chk("t2_issued", 32'(wlog.size() - base), 32'd4);
      for (int i = 0; i < 4; i++)
         if (base + i < wlog.size()) chk("t2_order", wlog[base+i].d, 32'h1000 + 32'(i));
      chk("t2_empty", 32'(fifo_count), 32'd0);

      // 3: push at full with grant is rejected; push at 3 with grant keeps 3
      ic_grant = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1; wr_n_addr = 2'(i); wr_data = 32'h2000 + 32'(i);
         step();
      end
      base = wlog.size();
      wr_data = 32'h2004; ic_grant = 1'b1;
      step();
      chk("t3_full_push_pop", 32'(fifo_count), 32'd3);
      wr_data = 32'h2005;
      step();
      chk("t3_push_pop_3", 32'(fifo_count), 32'd3);
      wr_valid = 1'b0;
      repeat (5) step();
      chk("t3_issued", 32'(wlog.size() - base), 32'd5);
      if (wlog.size() > 0) chk("t3_last", wlog[$].d, 32'h2005);

      // 4: write pushed alongside a read request goes first; read returns data
      ic_grant = 1'b1;
      wr_valid = 1'b1; wr_n_addr = 2'b00; wr_data = 32'hABABABAB;
      rd_req = 1'b1; rd_n_addr = 2'b01; exp_rd_addr = 2'b01;
      step();
      wr_valid = 1'b0;
      chk("t4_write_first", 32'(ic_write_en), 32'd1);
      chk("t4_write_data", ic_data_out, 32'hABABABAB);
      step(); step();
      chk("t4_read_en", 32'(ic_read_en), 32'd1);
      chk("t4_read_addr", 32'(ic_n_addr_out), 32'd1);
      chk("t4_busy", 32'(rd_busy), 32'd1);
      rd_req = 1'b0;
      step();
      chk("t4_wait_read_en", 32'(ic_read_en), 32'd0);
      step();
      ic_resp_valid = 1'b1; ic_data_in = 32'hBBBBBBAB;
      step();
      ic_resp_valid = 1'b0; ic_data_in = 32'h12345678;
      chk("t4_rd_done", 32'(rd_done), 32'd1);
      chk("t4_rd_err", 32'(rd_err), 32'd0);
      chk("t4_rd_data", rd_data, 32'hBBBBBBAB);
      chk("t4_not_busy", 32'(rd_busy), 32'd0);
      if (wlog.size() > 0) begin
         chk("t4_wlast", wlog[$].d, 32'hABABABAB);
         chk("t4_write_before_read", 32'(wlog_cyc[$] < rd_issue_cyc), 32'd1);
      end
      step();
      chk("t4_done_pulse", 32'(rd_done), 32'd0);
      chk("t4_data_hold", rd_data, 32'hBBBBBBAB);

      // 5: no response -> error pulse TMO cycles after entering wait
      rd_req = 1'b1; rd_n_addr = 2'b11; exp_rd_addr = 2'b11;
      step();
      rd_req = 1'b0;
      step();
      ic_grant = 1'b0;
      lat = 0;
      for (int k = 1; k <= TMO + 5; k++) begin
         step();
         if (rd_done) begin
            lat = k;
            break;
         end
      end
      chk("t5_latency", 32'(lat), 32'(TMO));
      chk("t5_rd_err", 32'(rd_err), 32'd1);
      chk("t5_rd_data_kept", rd_data, 32'hBBBBBBAB);
      step();
      chk("t5_done_pulse", 32'(rd_done), 32'd0);
      chk("t5_err_clear", 32'(rd_err), 32'd0);

      // 6: reset during wait with two queued writes aborts everything
      ic_grant = 1'b1;
      rd_req = 1'b1; rd_n_addr = 2'b10; exp_rd_addr = 2'b10;
      step();
      rd_req = 1'b0;
      step();
      ic_grant = 1'b0;
      for (int i = 0; i < 2; i++) begin
         wr_valid = 1'b1; wr_n_addr = 2'(i); wr_data = 32'h3000 + 32'(i);
         step();
      end
      wr_valid = 1'b0;
      chk("t6_count", 32'(fifo_count), 32'd2);
      chk("t6_busy", 32'(rd_busy), 32'd1);
      d0 = done_cnt;
      #2 reset = 1'b1;
      #1 chk_reset_outputs("t6_async");
      step(); step();
      reset = 1'b0;
      base = wlog.size();
      ic_grant = 1'b1;
      repeat (8) step();
      chk("t6_no_writes", 32'(wlog.size() - base), 32'd0);
      chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
      chk("t6_write_en", 32'(ic_write_en), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spike_port_initiator.md
Name: spike_port_initiator

Overview:
Core-side initiator for one port of the inter-core spike interconnect. It buffers neuron-addressed spike writes from a core in a FIFO and drives them onto the interconnect port one at a time with a grant handshake. It also issues single outstanding reads and returns the response data to the core, with a timeout. There is one instance per core, connected to the port signals of interconnect (n_addr, data, read_en, write_en).

Parameters:
ADDR_WIDTH, 2, neuron address width
DATA_WIDTH, 32, payload width
FIFO_DEPTH, 4, write FIFO entries (power of 2, >=2)
TIMEOUT, 15, max cycles in RD_WAIT before error (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
wr_valid  in  1  core presents write
wr_n_addr  in  ADDR_WIDTH  target neuron
wr_data  in  DATA_WIDTH  write payload
wr_ready  out  1  FIFO not full
rd_req  in  1  core read request (level, sampled in IDLE)
rd_n_addr  in  ADDR_WIDTH  read target neuron
rd_busy  out  1  read in progress
rd_done  out  1  one-cycle pulse, read finished
rd_data  out  DATA_WIDTH  read result, held until next rd_done
rd_err  out  1  qualifies rd_done: timeout occurred
ic_n_addr_out  out  ADDR_WIDTH  address to interconnect
ic_data_out  out  DATA_WIDTH  data to interconnect
ic_write_en  out  1  write command
ic_read_en  out  1  read command
ic_grant  in  1  interconnect accepts command this cycle
ic_resp_valid  in  1  read response valid
ic_data_in  in  DATA_WIDTH  read response data
fifo_count  out  log2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async): FIFO empty, state IDLE. Outputs: wr_ready=1, rd_busy=0, rd_done=0, rd_err=0, rd_data=0, ic_*_out=0, ic_write_en=0, ic_read_en=0, fifo_count=0.
- FIFO push when wr_valid&&wr_ready. Pop when a write is granted. Push and pop may occur in the same cycle, including when full: wr_ready reflects the registered count, so a push at full is not accepted even if a pop occurs that cycle. Pointers wrap modulo FIFO_DEPTH. A push while not ready is dropped, with no state change.
- FSM states: IDLE, WRITE, RD_REQ, RD_WAIT.
- IDLE: FIFO non-empty -> WRITE. Otherwise, if rd_req -> RD_REQ, latching rd_n_addr. Writes have priority, so a read is issued only after all earlier-pushed writes have drained.
- WRITE: drives ic_write_en=1 and the FIFO head on ic_n_addr_out/ic_data_out. The outputs are stable until ic_grant.
- On grant in WRITE: pop. If the FIFO still holds entries (count>1), stay in WRITE and present the next entry the following cycle. Otherwise go to IDLE. Throughput is therefore 1 write/cycle under continuous grant.
- RD_REQ: ic_read_en=1 and ic_n_addr_out=latched address. ic_data_out is held at 0. On ic_grant -> RD_WAIT, and the timeout counter clears.
- RD_WAIT: ic_read_en=0. On ic_resp_valid: rd_data<=ic_data_in, rd_done pulses the next cycle with rd_err=0, then IDLE.
- Timeout: if the counter reaches TIMEOUT with no response, rd_done pulses with rd_err=1, rd_data is unchanged, then IDLE.
- ic_resp_valid outside RD_WAIT is ignored.
- rd_busy=1 in RD_REQ and RD_WAIT. rd_req is ignored while busy. The core must drop rd_req after rd_done, otherwise a new read starts.
- Pushes are accepted in every state. Writes pushed during a read are issued after the read completes.
- ic_write_en and ic_read_en are never both 1. All ic_* outputs are registered or decoded from registered state only; there is no combinational path from ic_grant to ic_*_out.
- Reset mid-transaction: immediate abort, FIFO contents discarded, no rd_done.

Test Plan:
1. Reset, then push (01,A5A5A5A5) and (10,AAAAAAAA) with ic_grant=1 constant -> ic_write_en high 2 consecutive cycles with those pairs in order, fifo_count back to 0, state IDLE.
2. Hold ic_grant=0 and push 5 writes -> wr_ready=0 after 4 pushes, 5th dropped, fifo_count=4. Then grant -> exactly 4 writes issued in order.
3. Full FIFO, simultaneous push and grant -> push rejected, count=3. Then push with count=3 and grant in the same cycle -> count stays 3.
4. Push (00,ABABABAB), then rd_req addr 01 in the same cycle -> write issued first, then ic_read_en with addr 01. ic_resp_valid with BBBBBBAB two cycles after grant -> rd_done pulse, rd_data=BBBBBBAB, rd_err=0.
5. Read granted, no response -> rd_done with rd_err=1 exactly TIMEOUT cycles after entering RD_WAIT, rd_data retains its prior value.
6. Assert reset during RD_WAIT with 2 FIFO entries -> all outputs at reset values immediately, no rd_done, no further ic_write_en after release.
